dpram_rr_arbiter: RTL and testbench

- Shares one 1024x8 dual-port RAM (two independent read/write ports, registered read outputs) among NREQ requesters.
- Grants up to two requests per cycle, one per RAM port, in round-robin order.
- Never issues two accesses to the same address in one cycle when either access is a write.
- Routes read data back to the owning requester with a registered valid, one cycle after grant.

---
 rtl/dpram_rr_arbiter_pkg.sv | 21 ++
 rtl/dpram_rr_arbiter_rr_pick.sv | 27 ++
 rtl/dpram_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_dpram_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared constants, owner record and address-conflict rule for the dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 10;
    localparam int unsigned DW_DEF   = 8;

    // Index field is sized for the largest supported requester count (8).
    localparam int unsigned IDX_W = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } owner_t;

    function automatic logic conflict(input logic [31:0] addr_a, input logic we_a,
                                      input logic [31:0] addr_b, input logic we_b);
        return (addr_a == addr_b) && (we_a || we_b);
    endfunction

endpackage

// File: rtl/dpram_rr_arbiter_rr_pick.sv
// Combinational find-first-set over an eligibility mask, scanning upward from a start index with wrap.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IW'((32'(start) + k) % N);
            if (!found && mask[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NREQ requesters, up to two grants per cycle.
module dpram_rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic             ram_rd_wr1,
    output logic             ram_rd_wr2,
    output logic [AW-1:0]    ram_addr_1,
    output logic [AW-1:0]    ram_addr_2,
    output logic [DW-1:0]    ram_data_1,
    output logic [DW-1:0]    ram_data_2,
    input  logic [DW-1:0]    ram_o1,
    input  logic [DW-1:0]    ram_o2
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [AW-1:0] addr_s  [NREQ];
    logic [DW-1:0] wdata_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign addr_s[g]  = addr[g*AW +: AW];
        assign wdata_s[g] = wdata[g*DW +: DW];
    end

    logic [IW-1:0]   ptr;
    owner_t          own1, own2;
    logic            found1, found2, act1, act2;
    logic [IW-1:0]   p1, p2, p1_next, p2_next;
    logic [NREQ-1:0] mask2;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick1 (
        .mask  (req),
        .start (ptr),
        .found (found1),
        .idx   (p1)
    );

    // Port 2 scans on from the port-1 pick; conflicting requesters are skipped, not blocking.
    always_comb begin
        p1_next = (32'(p1) == NREQ - 1) ? '0 : p1 + IW'(1);
        p2_next = (32'(p2) == NREQ - 1) ? '0 : p2 + IW'(1);
        mask2   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            mask2[i] = found1 && req[i] && (IW'(i) != p1) &&
                       !conflict(32'(addr_s[i]), we[i], 32'(addr_s[p1]), we[p1]);
        end
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick2 (
        .mask  (mask2),
        .start (p1_next),
        .found (found2),
        .idx   (p2)
    );

    assign act1 = found1 && rst_n;
    assign act2 = found2 && rst_n;

    always_comb begin
        gnt = '0;
        if (act1) gnt[p1] = 1'b1;
        if (act2) gnt[p2] = 1'b1;
    end

    always_comb begin
        ram_rd_wr1 = act1 && we[p1];
        ram_addr_1 = act1 ? addr_s[p1]  : '0;
        ram_data_1 = act1 ? wdata_s[p1] : '0;
        ram_rd_wr2 = act2 && we[p2];
        ram_addr_2 = act2 ? addr_s[p2]  : '0;
        ram_data_2 = act2 ? wdata_s[p2] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            own1 <= '0;
            own2 <= '0;
        end else begin
            own1.valid <= act1 && !we[p1];
            own1.idx   <= IDX_W'(p1);
            own2.valid <= act2 && !we[p2];
            own2.idx   <= IDX_W'(p2);
            if (act2)
                ptr <= p2_next;
            else if (act1)
                ptr <= p1_next;
        end
    end

    // Owners always differ when both are valid, so the two ports never target the same slice.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (own1.valid && own1.idx == IDX_W'(i)) begin
                rvalid[i]         = 1'b1;
                rdata[i*DW +: DW] = ram_o1;
            end
            if (own2.valid && own2.idx == IDX_W'(i)) begin
                rvalid[i]         = 1'b1;
                rdata[i*DW +: DW] = ram_o2;
            end
        end
    end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Self-checking bench for dpram_rr_arbiter: directed scenarios plus random traffic against a scan-based model.
module tb_dpram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [N*DW-1:0] rdata;
    logic            ram_rd_wr1, ram_rd_wr2;
    logic [AW-1:0]   ram_addr_1, ram_addr_2;
    logic [DW-1:0]   ram_data_1, ram_data_2, ram_o1, ram_o2;

    logic [AW-1:0] a_v [N];
    logic [DW-1:0] d_v [N];

    always #5 clk = ~clk;

    always_comb begin
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = a_v[i];
            wdata[i*DW +: DW] = d_v[i];
        end
    end

    dpram_rr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ram_rd_wr1 (ram_rd_wr1),
        .ram_rd_wr2 (ram_rd_wr2),
        .ram_addr_1 (ram_addr_1),
        .ram_addr_2 (ram_addr_2),
        .ram_data_1 (ram_data_1),
        .ram_data_2 (ram_data_2),
        .ram_o1     (ram_o1),
        .ram_o2     (ram_o2)
    );

    // External RAM with a backdoor load port used only while the arbiter is held in reset.
    logic [DW-1:0] mem [1024];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else begin
            if (ram_rd_wr1) mem[ram_addr_1] <= ram_data_1;
            if (ram_rd_wr2) mem[ram_addr_2] <= ram_data_2;
        end
        ram_o1 <= mem[ram_addr_1];
        ram_o2 <= mem[ram_addr_2];
    end

    function automatic logic [7:0] pat(input int unsigned a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] shadow [1024];
    bit            pend_v [N];
    logic [DW-1:0] pend_d [N];
    logic [N-1:0]  exp_gnt, obs_gnt, obs_rvalid;
    logic [N*DW-1:0] obs_rdata;
    bit            active [N];
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_pick(output int p1, output int p2);
        int i;
        p1 = -1;
        p2 = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req[i]) begin p1 = i; break; end
        end
        if (p1 >= 0) begin
            for (int k = 1; k < N; k++) begin
                i = (p1 + k) % N;
                if (req[i] && !(a_v[i] == a_v[p1] && (we[i] || we[p1]))) begin
                    p2 = i;
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_d[i] = '0; end
    endtask

    // Called at a falling edge after inputs are set; returns at the next falling edge.
    task automatic step();
        int p1, p2;
        logic [18:0] e1, e2;
        #1;
        model_pick(p1, p2);
        exp_gnt = '0;
        if (p1 >= 0) exp_gnt[p1] = 1'b1;
        if (p2 >= 0) exp_gnt[p2] = 1'b1;
        e1 = (p1 >= 0) ? {we[p1], a_v[p1], d_v[p1]} : '0;
        e2 = (p2 >= 0) ? {we[p2], a_v[p2], d_v[p2]} : '0;
        obs_gnt    = gnt;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("ram_port1", 32'({ram_rd_wr1, ram_addr_1, ram_data_1}), 32'(e1));
        chk("ram_port2", 32'({ram_rd_wr2, ram_addr_2, ram_data_2}), 32'(e2));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'(pend_v[i]));
            chk($sformatf("rdata[%0d]", i), 32'(rdata[i*DW +: DW]), 32'(pend_v[i] ? pend_d[i] : 8'h00));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) pend_v[i] = 0;
        if (p1 >= 0 && !we[p1]) begin pend_v[p1] = 1; pend_d[p1] = shadow[a_v[p1]]; end
        if (p2 >= 0 && !we[p2]) begin pend_v[p2] = 1; pend_d[p2] = shadow[a_v[p2]]; end
        if (p1 >= 0 && we[p1]) shadow[a_v[p1]] = d_v[p1];
        if (p2 >= 0 && we[p2]) shadow[a_v[p2]] = d_v[p2];
        if (p2 >= 0) m_ptr = (p2 + 1) % N;
        else if (p1 >= 0) m_ptr = (p1 + 1) % N;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        bd_we   = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        for (int i = 0; i < N; i++) begin a_v[i] = '0; d_v[i] = '0; active[i] = 0; end
        model_reset();
        @(negedge clk);
        for (int a = 0; a < 1024; a++) begin
            bd_we   = 1'b1;
            bd_addr = AW'(a);
            bd_data = pat(a);
            shadow[a] = pat(a);
            @(negedge clk);
        end
        bd_we = 1'b0;

        // Reset with all requesting: no grants, no writes while rst_n is low.
        req = 4'b1111;
        for (int i = 0; i < N; i++) a_v[i] = AW'(10'h200 + i);
        #1;
        chk("rst_hold_gnt", 32'(gnt), 32'd0);
        chk("rst_hold_wr", 32'({ram_rd_wr1, ram_rd_wr2}), 32'd0);
        chk("rst_hold_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_gnt", 32'(obs_gnt), 32'h3);
        step();
        chk("second_gnt", 32'(obs_gnt), 32'hC);
        req = '0;
        step();

        // Write then read back through another requester.
        req = 4'b0001; we = 4'b0001; a_v[0] = 10'h010; d_v[0] = 8'hA5;
        step();
        req = 4'b0100; we = 4'b0000; a_v[2] = 10'h010;
        step();
        req = '0;
        step();
        chk("wr_rd_rvalid", 32'(obs_rvalid), 32'h4);
        chk("wr_rd_data2", 32'(obs_rdata[2*DW +: DW]), 32'hA5);
        chk("wr_rd_data01", 32'(obs_rdata[2*DW-1:0]), 32'd0);

        // Two writers to one address: the second is deferred, not blocked.
        do_reset();
        req = 4'b1010; we = 4'b1010;
        a_v[1] = 10'h3FF; a_v[3] = 10'h3FF; d_v[1] = 8'h11; d_v[3] = 8'h33;
        step();
        chk("wconf_gnt1", 32'(obs_gnt), 32'h2);
        req = 4'b1000;
        step();
        chk("wconf_gnt3", 32'(obs_gnt), 32'h8);
        req = 4'b0001; we = 4'b0000; a_v[0] = 10'h3FF;
        step();
        req = '0;
        step();
        chk("wconf_rdata", 32'(obs_rdata[0 +: DW]), 32'h33);

        // Same-address reads share a cycle.
        req = 4'b0100; we = 4'b0100; a_v[2] = 10'h055; d_v[2] = 8'h3C;
        step();
        req = 4'b0011; we = 4'b0000; a_v[0] = 10'h055; a_v[1] = 10'h055;
        step();
        chk("rr_same_gnt", 32'(obs_gnt), 32'h3);
        req = '0;
        step();
        chk("rr_same_rvalid", 32'(obs_rvalid), 32'h3);
        chk("rr_same_d0", 32'(obs_rdata[0 +: DW]), 32'h3C);
        chk("rr_same_d1", 32'(obs_rdata[DW +: DW]), 32'h3C);

        // Single requester streaming reads.
        req = 4'b0100; we = '0;
        for (int k = 0; k < 6; k++) begin
            a_v[2] = AW'(10'h100 + k);
            step();
            chk("stream_gnt", 32'(obs_gnt), 32'h4);
            if (k > 0) begin
                chk("stream_rvalid", 32'(obs_rvalid), 32'h4);
                chk("stream_rdata", 32'(obs_rdata[2*DW +: DW]), 32'(pat(32'h100 + k - 1)));
            end
        end
        req = '0;
        step();
        chk("stream_last", 32'(obs_rdata[2*DW +: DW]), 32'(pat(32'h105)));

        // Reset right after a read is accepted drops it and rewinds the pointer.
        do_reset();
        req = 4'b0010; we = '0; a_v[1] = 10'h020;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h2);
        @(posedge clk);
        #1;
        req = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rvalid_low", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rvalid_rel", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 4'b0111;
        for (int i = 0; i < N; i++) a_v[i] = AW'(10'h040 + i);
        step();
        chk("midrst_ptr0", 32'(obs_gnt), 32'h3);
        req = '0;
        step();

        // Random traffic on a small address window to provoke conflicts.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(3, 0) != 0) begin
                    active[i] = 1;
                    we[i]     = 1'($urandom_range(1, 0));
                    a_v[i]    = AW'(10'h300 + $urandom_range(3, 0));
                    d_v[i]    = 8'($urandom);
                end
                req[i] = active[i];
            end
            step();
            for (int i = 0; i < N; i++) if (exp_gnt[i]) active[i] = 0;
        end
        req = '0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
